// File: rtl/mod_addsub_pkg.sv
// Shared widths and state encoding for the limb-serial modular adder/subtractor.
package mod_addsub_pkg;
  localparam int LIMB_W  = 127;
  localparam int N_LIMBS = 3;
  localparam int N_BITS  = LIMB_W * N_LIMBS;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    P1   = 2'b01,
    P2   = 2'b10,
    DONE = 2'b11
  } state_e;
endpackage

// File: rtl/limb_addsub.sv
// One-limb add/subtract with carry/borrow in and out; cout is the borrow when sub=1.
module limb_addsub import mod_addsub_pkg::*; #(
  parameter int W = LIMB_W
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  input  logic         sub,
  output logic [W-1:0] z,
  output logic         cout
);
  logic [W:0] r;

  // A negative difference wraps, so bit W doubles as the borrow flag.
  always_comb begin
    if (sub) r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, cin};
    else     r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
  end

  assign z    = r[W-1:0];
  assign cout = r[W];
endmodule

// File: rtl/mod_addsub.sv
// (a +/- b) mod m computed limb-serially: P1 forms a+/-b, P2 forms the corrected value,
// and a final P2 cycle selects between them from registered flags.
module mod_addsub #(
  parameter int N      = mod_addsub_pkg::N_BITS,
  parameter int LIMB_W = mod_addsub_pkg::LIMB_W
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         subtract,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  input  logic         out_read,
  output logic [N-1:0] result,
  output logic         done
);
  import mod_addsub_pkg::*;

  localparam int NL = N / LIMB_W;
  typedef logic [NL-1:0][LIMB_W-1:0] limbs_t;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        cy_q, cy_d;
  logic        f1_q, f1_d;
  logic        sub_q, sub_d;
  limbs_t      a_q, a_d, b_q, b_d, m_q, m_d, s_q, s_d;
  logic [N-1:0] res_q, res_d;

  logic [LIMB_W-1:0] xa, xb, xs, xm, x, y, z;
  logic              op_sub, cout;

  limb_addsub #(.W(LIMB_W)) u_limb (
    .x(x), .y(y), .cin(cy_q), .sub(op_sub), .z(z), .cout(cout)
  );

  always_comb begin
    xa = '0; xb = '0; xs = '0; xm = '0;
    for (int i = 0; i < NL; i++) begin
      if (idx_q == 2'(i)) begin
        xa = a_q[i]; xb = b_q[i]; xs = s_q[i]; xm = m_q[i];
      end
    end
    // P1 combines the operands; P2 applies the modulus with the opposite operation.
    x      = (state_q == P2) ? xs : xa;
    y      = (state_q == P2) ? xm : xb;
    op_sub = (state_q == P2) ? ~sub_q : sub_q;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    f1_d    = f1_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    s_d     = s_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = in_a;
          b_d     = in_b;
          m_d     = in_m;
          sub_d   = subtract;
          cy_d    = 1'b0;
          idx_d   = 2'd0;
          state_d = P1;
        end
      end
      P1: begin
        for (int i = 0; i < NL; i++)
          if (idx_q == 2'(i)) s_d[i] = z;
        cy_d  = cout;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'(NL-1)) begin
          f1_d    = cout;
          cy_d    = 1'b0;
          idx_d   = 2'd0;
          state_d = P2;
        end
      end
      P2: begin
        if (idx_q == 2'(NL)) begin
          // a_q now holds t; add mode underflows only when c1=0 and s<m.
          if (sub_q) res_d = f1_q ? a_q : s_q;
          else       res_d = (cy_q & ~f1_q) ? s_q : a_q;
          idx_d   = 2'd0;
          state_d = DONE;
        end else begin
          for (int i = 0; i < NL; i++)
            if (idx_q == 2'(i)) a_d[i] = z;
          cy_d  = cout;
          idx_d = idx_q + 2'd1;
        end
      end
      DONE: begin
        if (out_read) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cy_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      res_q   <= res_d;
    end
  end

  always_ff @(posedge clk) begin
    f1_q  <= f1_d;
    sub_q <= sub_d;
    a_q   <= a_d;
    b_q   <= b_d;
    m_q   <= m_d;
    s_q   <= s_d;
  end

  assign result = res_q;
  assign done   = (state_q == DONE);
endmodule

// File: tb/tb_mod_addsub.sv
// Directed and random checks of mod_addsub against BLS12-381 p.
module tb_mod_addsub;
  localparam int N = 381;
  localparam logic [N-1:0] P = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

  logic         clk, resetn, start, subtract, out_read, done;
  logic [N-1:0] in_a, in_b, in_m, result;
  logic         tie, ack;
  int           n_chk, n_fail;

  assign out_read = tie ? done : ack;

  mod_addsub dut (
    .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
    .in_a(in_a), .in_b(in_b), .in_m(in_m), .out_read(out_read),
    .result(result), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called just after an edge with the DUT idle; returns with done observed or budget spent.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                        output logic [N-1:0] r, output int lat);
    in_a = a; in_b = b; subtract = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  function automatic logic [N-1:0] ref_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    logic [N:0] t;
    if (!s) begin
      t = {1'b0, a} + {1'b0, b};
      if (t >= {1'b0, P}) t = t - {1'b0, P};
    end else if (a >= b) begin
      t = {1'b0, a} - {1'b0, b};
    end else begin
      t = {1'b0, a} + {1'b0, P} - {1'b0, b};
    end
    return t[N-1:0];
  endfunction

  function automatic logic [N-1:0] rnd_mod_p();
    logic [383:0] r;
    for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
    r = r % {3'b000, P};
    return r[N-1:0];
  endfunction

  initial begin
    logic [N-1:0] r, a, b, big;
    int lat, bad;
    logic s;
    n_chk = 0; n_fail = 0;
    clk = 0; resetn = 0; start = 0; subtract = 0;
    in_a = '0; in_b = '0; in_m = P; tie = 0; ack = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_done", N'(done), N'(0));
    check("reset_result", result, '0);
    resetn = 1'b1;

    tie = 1'b1;
    run_op(N'(1), N'(1), 1'b0, r, lat);
    check("add_1_1", r, N'(2));
    check("add_1_1_lat", N'(lat), N'(7));
    @(posedge clk); #1;
    check("tied_done_pulse", N'(done), N'(0));
    check("tied_result_kept", result, N'(2));
    tie = 1'b0;

    run_op(P - N'(1), N'(1), 1'b0, r, lat); do_ack();
    check("add_pm1_1", r, '0);
    check("add_pm1_1_lat", N'(lat), N'(7));
    big = '0; big[127] = 1'b1;
    run_op(big - N'(1), N'(1), 1'b0, r, lat); do_ack();
    check("add_limb_carry", r, big);
    run_op(N'(1), N'(2), 1'b1, r, lat); do_ack();
    check("sub_1_2", r, P - N'(1));
    check("sub_1_2_lat", N'(lat), N'(7));
    run_op(N'(5), N'(5), 1'b1, r, lat); do_ack();
    check("sub_5_5", r, '0);

    run_op(P - N'(1), P - N'(1), 1'b0, r, lat);
    check("add_pm1_pm1", r, P - N'(2));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin start = 1'b1; in_a = N'(3); in_b = N'(4); subtract = 1'b0; end
      @(posedge clk); #1;
      start = 1'b0;
      if (done !== 1'b1 || result !== P - N'(2)) bad++;
    end
    check("hold_done_stable", N'(bad), N'(0));
    do_ack();
    check("ack_done_low", N'(done), N'(0));
    bad = 0;
    repeat (10) begin @(posedge clk); #1; if (done !== 1'b0) bad++; end
    check("start_in_done_ignored", N'(bad), N'(0));

    in_a = P - N'(1); in_b = N'(1); subtract = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    check("midrst_done", N'(done), N'(0));
    check("midrst_result", result, '0);
    bad = 0;
    repeat (10) begin @(posedge clk); #1; if (done !== 1'b0) bad++; end
    check("midrst_no_done", N'(bad), N'(0));
    run_op(N'(3), N'(4), 1'b0, r, lat); do_ack();
    check("add_3_4", r, N'(7));
    check("add_3_4_lat", N'(lat), N'(7));

    for (int k = 0; k < 4000; k++) begin
      a = rnd_mod_p();
      b = rnd_mod_p();
      if (k % 8 == 1) a = P - N'($urandom_range(1, 4));
      if (k % 8 == 2) b = P - N'($urandom_range(1, 4));
      s = 1'($urandom_range(0, 1));
      run_op(a, b, s, r, lat); do_ack();
      check("rand_result", r, ref_op(a, b, s));
      check("rand_lat", N'(lat), N'(7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
